// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the system writer, the tx FIFO and the UART transmitter.
// The overflow/ovf_clr pair exists only when UART_TX_FIFO_OVERFLOW_EN is defined.
interface uart_tx_fifo_if #(
  parameter int unsigned data_width = 8,
  parameter int unsigned depth      = 16
) ();
  localparam int unsigned CountW = $clog2(depth) + 1;

  logic                  wr_en;
  logic [data_width-1:0] wr_data;
  logic                  full;
  logic                  empty;
  logic [CountW-1:0]     count;
  logic                  tx_en;
  logic [data_width-1:0] data_in;
  logic                  busy;
`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic                  ovf_clr;
  logic                  overflow;

  modport master (
    output wr_en, wr_data, busy, ovf_clr,
    input  full, empty, count, tx_en, data_in, overflow
  );

  modport slave (
    input  wr_en, wr_data, busy, ovf_clr,
    output full, empty, count, tx_en, data_in, overflow
  );
`else
  modport master (
    output wr_en, wr_data, busy,
    input  full, empty, count, tx_en, data_in
  );

  modport slave (
    input  wr_en, wr_data, busy,
    output full, empty, count, tx_en, data_in
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in the tx_clk domain that launches stored words into the UART transmitter.
// Define UART_TX_FIFO_OVERFLOW_EN to add a sticky overflow flag with ovf_clr.
module uart_tx_fifo #(
  parameter int unsigned data_width = 8,
  parameter int unsigned depth      = 16
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned AddrW  = $clog2(depth);
  localparam int unsigned CountW = AddrW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LAUNCH  = 2'd1,
    SENDING = 2'd2
  } state_e;

  state_e                state_q;
  logic [data_width-1:0] mem_q [depth];
  logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]     count_q, count_d;
  logic                  full_q, empty_q;
  logic                  tx_en_q;
  logic [data_width-1:0] data_in_q;
  logic                  push_c, pop_c;

  // Fullness is judged on the registered count, before any same-cycle pop.
  assign push_c = bus.wr_en && !full_q;
  assign pop_c  = (state_q == LAUNCH) && bus.busy;

  always_comb begin : ptr_next
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + AddrW'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + AddrW'(1);
    end
    count_d = count_q + CountW'(push_c) - CountW'(pop_c);
  end

  always_ff @(posedge clk) begin : ptr_regs
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CountW'(depth));
      empty_q  <= (count_d == '0);
    end
  end

  // Storage array carries no reset; only slots between rd_ptr and wr_ptr are ever read.
  always_ff @(posedge clk) begin : storage
    if (!rst && push_c) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Launch FSM: present a word, wait for the transmitter to take it, wait for the frame to end.
  always_ff @(posedge clk) begin : launch_fsm
    if (rst) begin
      state_q   <= IDLE;
      tx_en_q   <= 1'b0;
      data_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!empty_q) begin
            state_q   <= LAUNCH;
            tx_en_q   <= 1'b1;
            data_in_q <= mem_q[rd_ptr_q];
          end
        end
        LAUNCH: begin
          if (bus.busy) begin
            state_q <= SENDING;
            tx_en_q <= 1'b0;
          end
        end
        SENDING: begin
          if (!bus.busy) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_en_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVERFLOW_EN
  logic overflow_q;

  // Sticky: a dropped write in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk) begin : ovf_reg
    if (rst) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && full_q) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.overflow = overflow_q;
`endif

  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;
  assign bus.tx_en   = tx_en_q;
  assign bus.data_in = data_in_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized self-checking bench for uart_tx_fifo: queue-based reference model plus a transmitter model.
module tb_uart_tx_fifo;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.data_width(DW), .depth(DEPTH)) bus ();

  uart_tx_fifo #(.data_width(DW), .depth(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, launch phase 0=waiting 1=offering 2=frame on line.
  logic [DW-1:0] mq[$];
  int            m_phase = 0;
  logic          m_tx_en = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_ovf   = 1'b0;
  logic          cmp_en  = 1'b0;

  always @(posedge clk) begin : model
    bit was_full, was_empty;
    if (rst) begin
      mq.delete();
      m_phase = 0;
      m_tx_en = 1'b0;
      m_data  = '0;
      m_ovf   = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (m_phase == 0) begin
        if (!was_empty) begin
          m_phase = 1;
          m_tx_en = 1'b1;
          m_data  = mq[0];
        end
      end else if (m_phase == 1) begin
        if (bus.busy) begin
          void'(mq.pop_front());
          m_tx_en = 1'b0;
          m_phase = 2;
        end
      end else begin
        if (!bus.busy) m_phase = 0;
      end
      if (bus.wr_en && !was_full) mq.push_back(bus.wr_data);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      if (bus.wr_en && was_full) m_ovf = 1'b1;
      else if (bus.ovf_clr) m_ovf = 1'b0;
`else
      m_ovf = 1'b0;
`endif
    end
  end

  always @(negedge clk) begin : compare
    if (cmp_en) begin
      chk("count",   32'(bus.count), 32'(mq.size()));
      chk("empty",   32'(bus.empty), 32'(mq.size() == 0));
      chk("full",    32'(bus.full),  32'(mq.size() == DEPTH));
      chk("tx_en",   32'(bus.tx_en), 32'(m_tx_en));
      chk("data_in", 32'(bus.data_in), 32'(m_data));
`ifdef UART_TX_FIFO_OVERFLOW_EN
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`endif
    end
  end

  // Transmitter model: busy rises tx_delay cycles after tx_en is seen and stays high tx_len cycles.
  int            tx_delay = 3;
  int            tx_len   = 10;
  bit            tx_hold  = 1'b0;
  logic [DW-1:0] rx_q[$];

  initial begin : xmtr
    int st  = 0;
    int cnt = 0;
    bus.busy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        st = 0;
        bus.busy = 1'b0;
      end else if (st == 0) begin
        if (bus.tx_en && !tx_hold) begin
          if (tx_delay == 0) begin
            bus.busy = 1'b1;
            rx_q.push_back(bus.data_in);
            cnt = tx_len;
            st  = 2;
          end else begin
            cnt = tx_delay;
            st  = 1;
          end
        end
      end else if (st == 1) begin
        cnt--;
        if (cnt == 0) begin
          bus.busy = 1'b1;
          rx_q.push_back(bus.data_in);
          cnt = tx_len;
          st  = 2;
        end
      end else begin
        cnt--;
        if (cnt <= 0) begin
          bus.busy = 1'b0;
          st = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic write_byte(input logic [DW-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.empty && !bus.tx_en && !bus.busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_bound", 32'(n < 2000), 32'd1);
    tick();
    tick();
  endtask

  initial begin : stim
    int n;
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h3C;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    bus.ovf_clr = 1'b0;
`endif
    @(posedge clk);
    cmp_en = 1'b1;
    #2;
    // Reset held three cycles with writes pending
    for (int i = 0; i < 3; i++) begin
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_tx_en", 32'(bus.tx_en), 32'd0);
      chk("rst_data",  32'(bus.data_in), 32'd0);
      tick();
    end
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    tick();

    // Single byte with a slow transmitter
    tx_delay = 3;
    tx_len   = 10;
    write_byte(8'hA5);
    chk("t2_count1", 32'(bus.count), 32'd1);
    chk("t2_tx_en_lo", 32'(bus.tx_en), 32'd0);
    tick();
    chk("t2_tx_en_hi", 32'(bus.tx_en), 32'd1);
    chk("t2_data", 32'(bus.data_in), 32'hA5);
    n = 0;
    while (!bus.busy && n < 50) begin tick(); n++; end
    chk("t2_busy_seen", 32'(bus.busy), 32'd1);
    tick();
    chk("t2_tx_en_fall", 32'(bus.tx_en), 32'd0);
    chk("t2_count0", 32'(bus.count), 32'd0);
    n = 0;
    while (bus.busy && n < 50) begin
      chk("t2_tx_en_hold", 32'(bus.tx_en), 32'd0);
      tick();
      n++;
    end
    wait_idle();

    // Burst to full, one dropped write, then drain in order
    rx_q.delete();
    tx_hold = 1'b1;
    for (int i = 1; i <= 16; i++) write_byte(DW'(i));
    chk("t3_full", 32'(bus.full), 32'd1);
    chk("t3_count16", 32'(bus.count), 32'd16);
    write_byte(8'hFF);
    chk("t3_drop_count", 32'(bus.count), 32'd16);
    chk("t3_head", 32'(bus.data_in), 32'h01);
    tx_delay = 0;
    tx_len   = 2;
    tx_hold  = 1'b0;
    wait_idle();
    chk("t3_rx_len", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < rx_q.size(); i++) chk("t3_rx_order", 32'(rx_q[i]), 32'(i + 1));
    chk("t3_empty", 32'(bus.empty), 32'd1);

    // Move pointers near the wrap point, then push on the same edge as a pop
    tx_len = 1;
    for (int i = 0; i < 12; i++) write_byte(DW'($urandom));
    wait_idle();
    rx_q.delete();
    tx_hold = 1'b1;
    for (int i = 0; i < 5; i++) write_byte(DW'(8'h40 + i));
    tick();
    chk("t4_count5", 32'(bus.count), 32'd5);
    chk("t4_launch", 32'(bus.tx_en), 32'd1);
    tx_hold = 1'b0;
    tick();
    chk("t4_busy", 32'(bus.busy), 32'd1);
    write_byte(8'h45);
    chk("t4_count_same", 32'(bus.count), 32'd5);
    tx_delay = 1;
    tx_len   = 3;
    wait_idle();
    chk("t4_rx_len", 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx_q.size(); i++) chk("t4_rx_order", 32'(rx_q[i]), 32'(8'h40 + i));

    // Reset while offering a word with seven queued
    tx_hold = 1'b1;
    for (int i = 0; i < 7; i++) write_byte(DW'(8'h70 + i));
    tick();
    chk("t5_count7", 32'(bus.count), 32'd7);
    chk("t5_launch", 32'(bus.tx_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_tx_en", 32'(bus.tx_en), 32'd0);
    chk("t5_count", 32'(bus.count), 32'd0);
    tx_hold = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_no_launch", 32'(bus.tx_en), 32'd0);
    end

`ifdef UART_TX_FIFO_OVERFLOW_EN
    // Sticky overflow: set, clear, and set winning over clear
    tx_hold = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(DW'(i));
    chk("t6_ovf_pre", 32'(bus.overflow), 32'd0);
    write_byte(8'hEE);
    chk("t6_ovf_set", 32'(bus.overflow), 32'd1);
    bus.ovf_clr = 1'b1;
    tick();
    chk("t6_ovf_clr", 32'(bus.overflow), 32'd0);
    write_byte(8'hEF);
    bus.ovf_clr = 1'b0;
    chk("t6_ovf_win", 32'(bus.overflow), 32'd1);
    tx_hold = 1'b0;
    wait_idle();
`endif

    // Random traffic with transmitter stalls and occasional resets
    for (int c = 0; c < 4000; c++) begin
      if ((c % 64) == 0) begin
        tx_delay = $urandom_range(0, 3);
        tx_len   = $urandom_range(1, 6);
        tx_hold  = ($urandom_range(0, 3) == 0);
      end
      bus.wr_en   = ($urandom_range(0, 99) < 45);
      bus.wr_data = DW'($urandom);
      rst         = ($urandom_range(0, 399) == 0);
`ifdef UART_TX_FIFO_OVERFLOW_EN
      bus.ovf_clr = ($urandom_range(0, 19) == 0);
`endif
      tick();
    end
    rst       = 1'b0;
    bus.wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVERFLOW_EN
    bus.ovf_clr = 1'b0;
`endif
    tx_hold = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
